uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, word length; legal values 5..8.
REQ-004 SHALL have parameter PARITY, default 0; 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1; legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4; power of two, at least 2.
REQ-007 clk_i  input  1  system clock; single clock domain; all logic on posedge.
REQ-008 rstn_i  input  1  reset, asynchronous, active-low.
REQ-009 uart_rx_i  input  1  asynchronous serial line, idle high.
REQ-010 ready_i  input  1  consumer accepts the head word when it is high together with valid_o.
REQ-011 valid_o  output  1  head word available (FIFO not empty).
REQ-012 data_o  output  DATA_BITS  head word, LSB first on the line.
REQ-013 parity_err_o  output  1  head word parity mismatch; 0 when PARITY=0.
REQ-014 frame_err_o  output  1  head word had a stop bit sampled low.
REQ-015 break_o  output  1  head word is all-zero data with frame error.
REQ-016 overrun_o  output  1  one-cycle pulse when a received word is dropped.

Function
REQ-017 uart_rx_i SHALL pass through a 2-FF synchronizer before any other use.
REQ-018 CPB = CLK_FREQ/BAUD_RATE (integer division) and HALF = CPB/2 SHALL be compile-time constants.
REQ-019 Each bit value SHALL be the majority of 3 synchronized samples at baud counts HALF-2, HALF-1 and HALF.
REQ-020 The baud counter SHALL be held at 0 in IDLE and otherwise count 0..CPB-1 and wrap.
REQ-021 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-022 IDLE->START SHALL occur on the first synchronized low.
REQ-023 In START, a majority-high at HALF SHALL return the FSM to IDLE (glitch reject) with nothing pushed; otherwise the FSM SHALL enter DATA at count CPB-1.
REQ-024 DATA SHALL shift in DATA_BITS bits, LSB first, each decided at HALF, and SHALL leave at CPB-1 of the last bit to PARITY (PARITY!=0) or STOP.
REQ-025 PARITY SHALL compare the sampled bit with the XOR of the data bits (even) or its inverse (odd), and SHALL move to STOP at CPB-1.
REQ-026 STOP SHALL sample STOP_BITS bits; any low stop bit SHALL set the frame error.
REQ-027 At HALF of the final stop bit, the FSM SHALL push {break, frame_err, parity_err, data} into the FIFO and return to IDLE in the same cycle.
REQ-028 break SHALL be set iff the data bits are 0, the frame error is set, and the parity bit (if any) is 0.
REQ-029 The FIFO SHALL be show-ahead: valid_o = not empty, and outputs SHALL reflect the head entry.
REQ-030 A pop SHALL occur on a cycle with valid_o and ready_i both high; outputs SHALL be held stable while valid_o=1 and ready_i=0.
REQ-031 Latency SHALL be: valid_o rises the cycle after a push into an empty FIFO.
REQ-032 When the FIFO is full, a push SHALL be dropped and overrun_o pulsed, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-033 Pointers SHALL be $clog2(FIFO_DEPTH) bits wide and wrap naturally; a count of width $clog2(FIFO_DEPTH)+1 SHALL distinguish full from empty.
REQ-034 A line held low continuously SHALL yield exactly one break word, and the FSM SHALL stay in IDLE until the line goes high, then low again.

Reset
REQ-035 While rstn_i=0: synchronizer flops =1, FSM=IDLE, counters=0, FIFO empty, shift register=0.
REQ-036 While rstn_i=0: valid_o, parity_err_o, frame_err_o, break_o and overrun_o SHALL be 0, and data_o SHALL be 0.
REQ-037 Reset mid-frame SHALL discard the partial word; after release the receiver SHALL wait for a fresh high-to-low edge.

Structure
REQ-038 A shared package uart_pkg SHALL hold the parity-mode encodings, the FSM state encodings, and the CPB/HALF calculation function.
REQ-039 The FIFO SHALL be one sub-module, sync_fifo, parametrised by width (DATA_BITS+3) and FIFO_DEPTH.

Verification
REQ-040 Defaults (CPB=217), send 0xA5 with 1 stop bit -> valid_o=1, data_o=0xA5, all error flags 0; valid_o drops after one ready_i cycle.
REQ-041 PARITY=1, DATA_BITS=7, send 0x35 with parity bit 1 -> parity_err_o=1; repeat with parity 0 -> parity_err_o=0.
REQ-042 Low pulse of 50 clocks on idle line -> no push, FSM back in IDLE, valid_o stays 0.
REQ-043 Line held low for 20 bit times -> exactly one word: data_o=0x00, frame_err_o=1, break_o=1.
REQ-044 FIFO_DEPTH=4, ready_i=0, send 5 words -> overrun_o pulses once on the 5th word; 4 words pop in order.
REQ-045 Assert rstn_i in the middle of bit 3 of a frame, then send 0x3C -> only 0x3C is received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: parity modes, FSM states and
// baud-timing helpers.
package uart_pkg;

  localparam int unsigned ParityNone = 0;
  localparam int unsigned ParityEven = 1;
  localparam int unsigned ParityOdd  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  function automatic int unsigned calc_cpb(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int unsigned calc_half(input int unsigned cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is dropped (and flagged)
// unless a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             overrun_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CountFull = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             r_overrun;

  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == CountFull);
  assign empty_o = (r_count == '0);
  assign w_pop   = pop_i & ~empty_o;
  assign w_push  = push_i & (~w_full | w_pop);

  assign rdata_o   = r_mem[r_rptr];
  assign overrun_o = r_overrun;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= push_i & ~w_push;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised line, 3-sample majority voting per bit,
// optional parity, 1 or 2 stop bits, words queued in a show-ahead FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 25000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 uart_rx_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 break_o,
  output logic                 overrun_o
);

  localparam int unsigned CPB   = calc_cpb(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF  = calc_half(CPB);
  localparam int unsigned CntW  = $clog2(CPB);
  localparam int unsigned BitW  = $clog2(DATA_BITS);
  localparam int unsigned WordW = DATA_BITS + 3;

  localparam logic [CntW-1:0] CntLast = CntW'(CPB - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(HALF);
  localparam logic [CntW-1:0] CntS0   = CntW'(HALF - 2);
  localparam logic [CntW-1:0] CntS1   = CntW'(HALF - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS - 1);
  localparam logic            StopLast = 1'(STOP_BITS - 1);
  localparam logic            HasPar  = (PARITY != ParityNone);
  localparam logic            OddPar  = (PARITY == ParityOdd);

  rx_state_e r_state;
  rx_state_e w_state_next;

  logic [1:0]           r_sync;
  logic [1:0]           r_flush;
  logic                 r_armed;
  logic [CntW-1:0]      r_cnt;
  logic [BitW-1:0]      r_bit;
  logic                 r_stop;
  logic [DATA_BITS-1:0] r_shift;
  logic [1:0]           r_smp;
  logic                 r_ferr;
  logic                 r_perr;
  logic                 r_par;

  logic             w_rx;
  logic             w_maj;
  logic             w_at_half;
  logic             w_at_last;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_ferr_final;
  logic             w_brk;
  logic [WordW-1:0] w_push_word;
  logic [WordW-1:0] w_head;

  assign w_rx      = r_sync[1];
  assign w_maj     = (r_smp[0] & r_smp[1]) | (r_smp[0] & w_rx) | (r_smp[1] & w_rx);
  assign w_at_half = (r_cnt == CntHalf);
  assign w_at_last = (r_cnt == CntLast);

  assign w_push       = (r_state == StStop) && w_at_half && (r_stop == StopLast);
  assign w_ferr_final = r_ferr | ~w_maj;
  assign w_brk        = (r_shift == '0) & w_ferr_final & (~HasPar | ~r_par);
  assign w_push_word  = {w_brk, w_ferr_final, r_perr, r_shift};

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (!w_rx && r_armed) w_state_next = StStart;
      end
      StStart: begin
        if (w_at_half && w_maj) w_state_next = StIdle;
        else if (w_at_last)     w_state_next = StData;
      end
      StData: begin
        if (w_at_last && (r_bit == LastBit)) w_state_next = HasPar ? StParity : StStop;
      end
      StParity: begin
        if (w_at_last) w_state_next = StStop;
      end
      StStop: begin
        if (w_push) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sync  <= 2'b11;
      r_flush <= 2'b00;
      r_armed <= 1'b0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_shift <= '0;
      r_smp   <= 2'b11;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      r_par   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], uart_rx_i};
      r_flush <= {r_flush[0], 1'b1};
      // Arm only on a genuine high seen after the synchroniser's reset value
      // has flushed, so a line stuck low never starts a frame on its own.
      r_armed <= (r_state == StIdle) ? (r_armed | (w_rx & r_flush[1])) : 1'b0;

      if ((w_state_next == StIdle) || w_at_last) r_cnt <= '0;
      else                                       r_cnt <= r_cnt + 1'b1;

      if (r_cnt == CntS0) r_smp[0] <= w_rx;
      if (r_cnt == CntS1) r_smp[1] <= w_rx;

      unique case (r_state)
        StIdle: begin
          r_bit  <= '0;
          r_stop <= 1'b0;
          r_ferr <= 1'b0;
          r_perr <= 1'b0;
          r_par  <= 1'b0;
        end
        StData: begin
          if (w_at_half) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
          if (w_at_last) r_bit <= (r_bit == LastBit) ? '0 : r_bit + 1'b1;
        end
        StParity: begin
          if (w_at_half) begin
            r_par  <= w_maj;
            r_perr <= w_maj ^ (^r_shift) ^ OddPar;
          end
        end
        StStop: begin
          if (w_at_half) r_ferr <= w_ferr_final;
          if (w_at_last) r_stop <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_pop = valid_o & ready_i;

  sync_fifo #(
    .WIDTH(WordW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .push_i   (w_push),
    .wdata_i  (w_push_word),
    .pop_i    (w_pop),
    .rdata_o  (w_head),
    .empty_o  (w_empty),
    .overrun_o(overrun_o)
  );

  // Head memory is not reset, so gate everything with valid to keep outputs 0 when empty.
  assign valid_o      = ~w_empty;
  assign data_o       = valid_o ? w_head[DATA_BITS-1:0] : '0;
  assign parity_err_o = valid_o & w_head[DATA_BITS];
  assign frame_err_o  = valid_o & w_head[DATA_BITS+1];
  assign break_o      = valid_o & w_head[DATA_BITS+2];

endmodule
